// File: rtl/seg7_scan_mux.sv
// Scan driver for a common-anode multi-digit 7-segment display: one BCD nibble plus an active-low digit enable per
// slot, a blank cycle at every digit change, and frame-aligned display updates. Optional: SEG7_LEADING_ZERO_BLANK_EN.
module seg7_scan_mux #(
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE   = 50000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  output logic [3:0]              bcd,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_start
);

  localparam int PW = $clog2(PRESCALE);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] ONE_HOT0 = NUM_DIGITS'(1);

  logic [PW-1:0]           pre_q, pre_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] pend_q, pend_d;
  logic                    pend_v_q, pend_v_d;
  logic [4*NUM_DIGITS-1:0] disp_q, disp_d;
  logic                    armed_q, armed_d;
  logic [3:0]              bcd_q, bcd_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    fs_q, fs_d;
  logic                    tick, boundary;

  function automatic logic [3:0] digit_nibble(input logic [4*NUM_DIGITS-1:0] v,
                                              input logic [IW-1:0] i);
    logic [3:0] nib;
    nib = v[4*i +: 4];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    begin
      logic zero_above;
      zero_above = 1'b1;
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (k >= int'(i) && v[4*k +: 4] != 4'h0) zero_above = 1'b0;
      end
      if (i != '0 && zero_above) nib = 4'hF;
    end
`endif
    return nib;
  endfunction

  always_comb begin
    tick     = en && (pre_q == PRE_LAST);
    boundary = tick && (idx_q == IDX_LAST);
    pre_d    = pre_q;
    idx_d    = idx_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    disp_d   = disp_q;
    armed_d  = armed_q | tick;
    bcd_d    = bcd_q;
    an_d     = '1;
    fs_d     = 1'b0;

    if (en) pre_d = tick ? '0 : pre_q + PW'(1);
    if (tick) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);

    // A load landing on the boundary bypasses pend so it is visible one cycle later.
    if (boundary && load) begin
      disp_d   = digits_in;
      pend_v_d = 1'b0;
    end else if (boundary && pend_v_q) begin
      disp_d   = pend_q;
      pend_v_d = 1'b0;
    end else if (load) begin
      pend_d   = digits_in;
      pend_v_d = 1'b1;
    end

    // The tick cycle itself is the blank slot; the new digit lights one cycle later.
    if (en && armed_q && !tick) an_d = ~(ONE_HOT0 << idx_q);
    if (tick) begin
      bcd_d = digit_nibble(disp_d, idx_d);
      fs_d  = (idx_d == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q    <= '0;
      idx_q    <= '0;
      pend_q   <= '1;
      pend_v_q <= 1'b0;
      disp_q   <= '1;
      armed_q  <= 1'b0;
      bcd_q    <= 4'hF;
      an_q     <= '1;
      fs_q     <= 1'b0;
    end else begin
      pre_q    <= pre_d;
      idx_q    <= idx_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      disp_q   <= disp_d;
      armed_q  <= armed_d;
      bcd_q    <= bcd_d;
      an_q     <= an_d;
      fs_q     <= fs_d;
    end
  end

  assign bcd         = bcd_q;
  assign an          = an_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Bench for seg7_scan_mux (NUM_DIGITS=4, PRESCALE=4): table of the first scan, directed load/enable/reset
// sequences, then random traffic, all checked against a scan-position model kept here.
module tb_seg7_scan_mux;
  localparam int N = 4;
  localparam int P = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        load = 1'b0;
  logic [15:0] digits_in = '0;
  logic [3:0]  bcd;
  logic [3:0]  an;
  logic        frame_start;

  seg7_scan_mux #(.NUM_DIGITS(N), .PRESCALE(P)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .digits_in(digits_in),
    .bcd(bcd), .an(an), .frame_start(frame_start)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Reference model: one scan position counter over the whole frame, a list of pending loads.
  int          m_pos;
  logic [15:0] m_disp;
  logic [15:0] pend_list[$];
  bit          m_started;
  logic [3:0]  m_bcd;
  logic [8:0]  exp_q[$];

  function automatic logic [3:0] m_nib(input logic [15:0] v, input int d);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    if (d > 0 && (v >> (4 * d)) == 16'h0) return 4'hF;
`endif
    return 4'((v >> (4 * d)) & 16'hF);
  endfunction

  task automatic model_reset();
    m_pos = 0;
    m_disp = 16'hFFFF;
    pend_list.delete();
    m_started = 0;
    m_bcd = 4'hF;
    exp_q.delete();
  endtask

  task automatic model_step(input logic e, input logic l, input logic [15:0] d);
    int d_old, d_new;
    bit tick, bnd, fs_e;
    logic [3:0] an_e;
    d_old = m_pos / P;
    tick  = e && (m_pos % P == P - 1);
    bnd   = tick && (d_old == N - 1);
    if (bnd) begin
      if (l) m_disp = d;
      else if (pend_list.size() > 0) m_disp = pend_list[$];
      pend_list.delete();
    end else if (l) begin
      pend_list.push_back(d);
    end
    if (e) m_pos = (m_pos + 1) % (N * P);
    d_new = m_pos / P;
    an_e = (e && m_started && !tick) ? 4'(~(1 << d_old)) : 4'hF;
    if (tick) m_bcd = m_nib(m_disp, d_new);
    fs_e = tick && (d_new == 0);
    if (tick) m_started = 1;
    exp_q.push_back({an_e, m_bcd, fs_e});
  endtask

  // Scoreboard
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Drivers
  task automatic step(input logic e, input logic l, input logic [15:0] d);
    logic [8:0] exp;
    en = e;
    load = l;
    digits_in = d;
    model_step(e, l, d);
    @(posedge clk);
    #1;
    cyc++;
    exp = exp_q.pop_front();
    chk("model_an_bcd_fs", {23'd0, an, bcd, frame_start}, {23'd0, exp});
  endtask

  task automatic do_reset();
    en = 1'b0;
    load = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    cyc = 0;
  endtask

  typedef struct {
    logic       en;
    logic       load;
    logic [15:0] din;
    logic [3:0] an;
    logic [3:0] bcd;
    logic       fs;
  } vec_t;

  vec_t tbl[20];

  initial begin
    logic [3:0] an_seq[20];
    logic [8:0] exp;
    an_seq = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hD, 4'hD, 4'hD, 4'hF, 4'hB, 4'hB,
               4'hB, 4'hF, 4'h7, 4'h7, 4'h7, 4'hF, 4'hE, 4'hE, 4'hE, 4'hF};
    for (int i = 0; i < 20; i++) begin
      tbl[i].en   = 1'b1;
      tbl[i].load = 1'b0;
      tbl[i].din  = 16'h0;
      tbl[i].an   = an_seq[i];
      tbl[i].bcd  = 4'hF;
      tbl[i].fs   = (i == 15);
    end

    // First scan after reset, no load
    do_reset();
    chk("reset_values", {23'd0, an, bcd, frame_start}, {23'd0, 4'hF, 4'hF, 1'b0});
    for (int i = 0; i < 20; i++) begin
      en = tbl[i].en;
      load = tbl[i].load;
      digits_in = tbl[i].din;
      model_step(tbl[i].en, tbl[i].load, tbl[i].din);
      @(posedge clk);
      #1;
      cyc++;
      exp = exp_q.pop_front();
      chk("table", {23'd0, an, bcd, frame_start}, {23'd0, tbl[i].an, tbl[i].bcd, tbl[i].fs});
      chk("table_model", {23'd0, an, bcd, frame_start}, {23'd0, exp});
    end

    // Mid-frame load, double load, boundary load, enable dropout
    do_reset();
    for (int c = 0; c < 80; c++) begin
      logic e, l;
      logic [15:0] d;
      e = 1'b1;
      l = 1'b0;
      d = 16'($urandom);
      case (c)
        5:  begin l = 1'b1; d = 16'h1234; end
        33: begin l = 1'b1; d = 16'h1111; end
        40: begin l = 1'b1; d = 16'h9876; end
        63: begin l = 1'b1; d = 16'h5555; end
        79: begin l = 1'b1; d = 16'hABCD; end
        default: ;
      endcase
      if (c >= 66 && c <= 75) e = 1'b0;
      step(e, l, d);
      case (cyc)
        15: chk("blank_before_boundary", {28'd0, bcd}, 32'hF);
        16: chk("boundary_digit0", {27'd0, bcd, frame_start}, {27'd0, 4'h4, 1'b1});
        21: chk("digit1_1234", {24'd0, an, bcd}, {24'd0, 4'hD, 4'h3});
        25: chk("digit2_1234", {24'd0, an, bcd}, {24'd0, 4'hB, 4'h2});
        29: chk("digit3_1234", {24'd0, an, bcd}, {24'd0, 4'h7, 4'h1});
        48: chk("last_load_wins0", {27'd0, bcd, frame_start}, {27'd0, 4'h6, 1'b1});
        52: chk("last_load_wins1", {28'd0, bcd}, 32'h7);
        56: chk("last_load_wins2", {28'd0, bcd}, 32'h8);
        60: chk("last_load_wins3", {28'd0, bcd}, 32'h9);
        64: chk("boundary_load", {27'd0, bcd, frame_start}, {27'd0, 4'h5, 1'b1});
        67: chk("en_low_blank", {28'd0, an}, 32'hF);
        76: chk("en_low_hold", {28'd0, an}, 32'hF);
        77: chk("resume_digit0", {28'd0, an}, 32'hE);
        78: chk("resume_pre_held", {24'd0, an, bcd}, {24'd0, 4'hF, 4'h5});
        79: chk("resume_digit1", {28'd0, an}, 32'hD);
        default: ;
      endcase
    end

    // Asynchronous reset mid-scan discards the pending load
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", {23'd0, an, bcd, frame_start}, {23'd0, 4'hF, 4'hF, 1'b0});
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    cyc = 0;
    en = 1'b1;
    for (int c = 0; c < 24; c++) step(1'b1, 1'b0, 16'h0);
    chk("pend_discarded", {28'd0, bcd}, 32'hF);

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    do_reset();
    for (int c = 0; c < 40; c++) begin
      if (c == 0) step(1'b1, 1'b1, 16'h0042);
      else if (c == 30) step(1'b1, 1'b1, 16'h0000);
      else step(1'b1, 1'b0, 16'h0);
      case (cyc)
        16: chk("lzb_d0", {28'd0, bcd}, 32'h2);
        20: chk("lzb_d1", {28'd0, bcd}, 32'h4);
        24: chk("lzb_d2", {28'd0, bcd}, 32'hF);
        28: chk("lzb_d3", {28'd0, bcd}, 32'hF);
        32: chk("lzb_zero_d0", {28'd0, bcd}, 32'h0);
        36: chk("lzb_zero_d1", {28'd0, bcd}, 32'hF);
        default: ;
      endcase
    end
`endif

    // Random traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      step($urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0, 16'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
